// File: rtl/sigdel_adc_decimator_if.sv
// Sample-path bundle for the sigma-delta ADC decimator.
//   bit_in       : comparator bitstream (asynchronous to the system clock)
//   fb_out       : feedback bit for the external RC integrator pin
//   sample_out   : signed decimated PCM sample
//   sample_valid : one-cycle strobe qualifying sample_out
//   sat          : sample was clipped (meaningful with sample_valid)
// master = decimator side, slave = comparator/consumer side.
interface sigdel_adc_decimator_if #(
  parameter int unsigned BITLEN = 16
) ();
  logic                     bit_in;
  logic                     fb_out;
  logic signed [BITLEN-1:0] sample_out;
  logic                     sample_valid;
  logic                     sat;

  modport master (
    input  bit_in,
    output fb_out,
    output sample_out,
    output sample_valid,
    output sat
  );

  modport slave (
    output bit_in,
    input  fb_out,
    input  sample_out,
    input  sample_valid,
    input  sat
  );
endinterface

// File: rtl/sigdel_adc_decimator.sv
// Sigma-delta ADC back end: synchronizes the comparator bitstream, drives the
// feedback pin, and decimates with a 3rd-order CIC (sinc3) filter into signed
// BITLEN-bit samples.
// Ports:
//   sysclk : system clock, all state on its rising edge
//   rst_n  : asynchronous active-low reset
//   adc    : sample-path bundle (master side), see sigdel_adc_decimator_if
module sigdel_adc_decimator #(
  parameter int unsigned BITLEN = 16,
  parameter int unsigned DECIM  = 256
) (
  input logic                     sysclk,
  input logic                     rst_n,
  sigdel_adc_decimator_if.master  adc
);

  localparam int unsigned L     = $clog2(DECIM);
  localparam int unsigned W     = 3 * L + 1;
  localparam int unsigned SHIFT = W - 1 - BITLEN;

  localparam int          YMaxI = (1 << (BITLEN - 1)) - 1;
  localparam int          YMinI = -(1 << (BITLEN - 1));

  // Mid-scale of the comb output (half the ones-count range).
  localparam logic [W:0]        Half = (W + 1)'(1) << (W - 2);
  localparam logic signed [W:0] YMax = (W + 1)'(YMaxI);
  localparam logic signed [W:0] YMin = (W + 1)'(YMinI);

  logic              s1_q, s2_q, fb_q;
  logic [W-1:0]      i1_q, i2_q, i3_q;
  logic [W-1:0]      i1_d, i2_d, i3_d;
  logic [W-1:0]      d1_q, d2_q, d3_q;
  logic [W-1:0]      c1, c2, c3;
  logic [L-1:0]      cnt_q;
  logic [1:0]        warm_q, warm_d;
  logic              tick;
  logic              emit;

  logic signed [W:0]        x, y;
  logic signed [BITLEN-1:0] sample_d, sample_q;
  logic                     sat_d, sat_q;
  logic                     valid_q;

  // Synchronizer and feedback flop.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      fb_q <= 1'b0;
    end else begin
      s1_q <= adc.bit_in;
      s2_q <= s1_q;
      fb_q <= s2_q;
    end
  end

  // Integrators wrap modulo 2^W; the comb differences undo the wrap exactly.
  always_comb begin
    i1_d = i1_q + {{(W - 1){1'b0}}, s2_q};
    i2_d = i2_q + i1_q;
    i3_d = i3_q + i2_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      i3_q <= i3_d;
    end
  end

  assign tick = (cnt_q == L'(DECIM - 1));
  assign emit = tick && (warm_q == 2'd3);

  // Warm-up saturates at 3 so the first three ticks only prime the comb delays.
  always_comb begin
    warm_d = warm_q;
    if (tick && (warm_q != 2'd3)) begin
      warm_d = warm_q + 2'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      warm_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      warm_q <= warm_d;
    end
  end

  // Comb section evaluated combinationally, committed on the tick.
  always_comb begin
    c1 = i3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else if (tick) begin
      d1_q <= i3_q;
      d2_q <= c1;
      d3_q <= c2;
    end
  end

  // Re-centre the unsigned ones count around zero, scale, then clip.
  always_comb begin
    x        = $signed({1'b0, c3}) - $signed(Half);
    y        = x >>> SHIFT;
    sample_d = y[BITLEN-1:0];
    sat_d    = 1'b0;
    if (y > YMax) begin
      sample_d = {1'b0, {(BITLEN - 1){1'b1}}};
      sat_d    = 1'b1;
    end else if (y < YMin) begin
      sample_d = {1'b1, {(BITLEN - 1){1'b0}}};
      sat_d    = 1'b1;
    end
  end

  // Sample and sat hold between strobes.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        sample_q <= sample_d;
        sat_q    <= sat_d;
      end
    end
  end

  assign adc.fb_out       = fb_q;
  assign adc.sample_out   = sample_q;
  assign adc.sample_valid = valid_q;
  assign adc.sat          = sat_q;

endmodule
